// File: rtl/axi_read_arbiter_if.sv
// Bundle of client request/return, write-hazard and AXI AR/R signals for axi_read_arbiter.
// "master" is the arbiter's view; "slave" is the view of the caches, write path and AXI port.
interface axi_read_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
);
    logic              ic_rd_req;
    logic [ADDR_W-1:0] ic_rd_addr;
    logic [LEN_W-1:0]  ic_rd_len;
    logic              ic_rd_gnt;
    logic              ic_rd_valid;
    logic              ic_rd_last;

    logic              dc_rd_req;
    logic [ADDR_W-1:0] dc_rd_addr;
    logic [LEN_W-1:0]  dc_rd_len;
    logic              dc_rd_gnt;
    logic              dc_rd_valid;
    logic              dc_rd_last;

    logic [31:0]       rd_data;
    logic              wr_busy;

    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic              arvalid;
    logic              arready;
    logic [3:0]        arid;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;

    logic [31:0]       rdata;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        input  ic_rd_req, ic_rd_addr, ic_rd_len,
        output ic_rd_gnt, ic_rd_valid, ic_rd_last,
        input  dc_rd_req, dc_rd_addr, dc_rd_len,
        output dc_rd_gnt, dc_rd_valid, dc_rd_last,
        output rd_data,
        input  wr_busy,
        output araddr, arlen, arvalid, arid, arsize, arburst, arlock, arcache, arprot,
        input  arready,
        input  rdata, rlast, rvalid,
        output rready
    );

    modport slave (
        output ic_rd_req, ic_rd_addr, ic_rd_len,
        input  ic_rd_gnt, ic_rd_valid, ic_rd_last,
        output dc_rd_req, dc_rd_addr, dc_rd_len,
        input  dc_rd_gnt, dc_rd_valid, dc_rd_last,
        input  rd_data,
        output wr_busy,
        input  araddr, arlen, arvalid, arid, arsize, arburst, arlock, arcache, arprot,
        output arready,
        output rdata, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between icache and dcache, one burst outstanding at a time.
// Define ARB_RR_EN for round-robin arbitration; default is fixed dcache-first priority.
module axi_read_arbiter #(
    parameter int LEN_W  = 4,
    parameter int ADDR_W = 32
) (
    input logic               clk,
    input logic               rst,
    axi_read_arbiter_if.master bus
);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    logic [1:0]        state;
    logic              owner;
    logic [LEN_W-1:0]  beat_cnt;
    logic              arvalid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [LEN_W-1:0]  arlen_q;

    logic dc_elig;
    logic ic_elig;
    logic pick;
    logic ar_done;
    logic r_beat;

    // A dcache read must not overtake a write still in flight on AW/W/B.
    assign dc_elig = bus.dc_rd_req && !bus.wr_busy;
    assign ic_elig = bus.ic_rd_req;
    assign ar_done = (state == R_AR) && bus.arready;
    assign r_beat  = (state == R_DATA) && bus.rvalid;

`ifdef ARB_RR_EN
    logic rr_ptr;

    // rr_ptr remembers the last granted client; a tie goes to the other one.
    always_comb begin
        pick = OWN_IC;
        if (dc_elig && ic_elig) begin
            pick = ~rr_ptr;
        end else if (dc_elig) begin
            pick = OWN_DC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= OWN_IC;
        end else if (ar_done) begin
            rr_ptr <= owner;
        end
    end
`else
    always_comb begin
        pick = OWN_IC;
        if (dc_elig) begin
            pick = OWN_DC;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= R_IDLE;
            owner     <= OWN_IC;
            beat_cnt  <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
        end else begin
            case (state)
                R_IDLE: begin
                    if (dc_elig || ic_elig) begin
                        owner     <= pick;
                        araddr_q  <= (pick == OWN_DC) ? bus.dc_rd_addr : bus.ic_rd_addr;
                        arlen_q   <= (pick == OWN_DC) ? bus.dc_rd_len  : bus.ic_rd_len;
                        arvalid_q <= 1'b1;
                        state     <= R_AR;
                    end
                end
                R_AR: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    // rlast ends the burst; the counter only tracks progress.
                    if (bus.rvalid) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (bus.rlast) begin
                            state <= R_IDLE;
                        end
                    end
                end
                default: begin
                    state <= R_IDLE;
                end
            endcase
        end
    end

    assign bus.araddr  = araddr_q;
    assign bus.arlen   = arlen_q;
    assign bus.arvalid = arvalid_q;
    assign bus.arid    = 4'd0;
    assign bus.arsize  = 3'd2;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'd0;
    assign bus.arcache = 4'd0;
    assign bus.arprot  = 3'd0;

    assign bus.rready  = (state == R_DATA);
    assign bus.rd_data = (state == R_DATA) ? bus.rdata : 32'd0;

    assign bus.ic_rd_gnt   = ar_done && (owner == OWN_IC);
    assign bus.dc_rd_gnt   = ar_done && (owner == OWN_DC);
    assign bus.ic_rd_valid = r_beat && (owner == OWN_IC);
    assign bus.dc_rd_valid = r_beat && (owner == OWN_DC);
    assign bus.ic_rd_last  = r_beat && (owner == OWN_IC) && bus.rlast;
    assign bus.dc_rd_last  = r_beat && (owner == OWN_DC) && bus.rlast;

endmodule
